// File: rtl/run_controller_pkg.sv
// Shared definitions for run_controller: command codes, FSM states and default widths.
package run_controller_pkg;

  localparam int ARG_W_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int PC_W_DEF  = 16;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_HALT       = 3'd1,
    CMD_RUN        = 3'd2,
    CMD_STEP_CYC   = 3'd3,
    CMD_STEP_INSTR = 3'd4,
    CMD_RUN_N      = 3'd5,
    CMD_SET_BP     = 3'd6,
    CMD_CLR_BP     = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_HALTED     = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_CYC   = 3'd2,
    ST_STEP_INSTR = 3'd3,
    ST_RUN_N      = 3'd4
  } state_e;

  // Commands that start execution; only legal from HALTED.
  function automatic logic is_go(cmd_e c);
    return c inside {CMD_RUN, CMD_STEP_CYC, CMD_STEP_INSTR, CMD_RUN_N};
  endfunction

endpackage

// File: rtl/run_controller_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_rise
);

  // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] sh_q, sh_d;

  always_comb sh_d = {sh_q[1:0], i_d};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) sh_q <= '0;
    else         sh_q <= sh_d;
  end

  assign o_rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/run_controller.sv
// CPU clock-enable sequencer for the debug path: run/halt/step/run-N with cycle and instruction counters.
// Breakpoint register and compare are built only when RUN_CTRL_BREAKPOINT_EN is defined.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int ARG_W     = ARG_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PC_W      = PC_W_DEF,
  parameter int RESET_RUN = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmdValid,
  input  logic [2:0]       i_cmd,
  input  logic [ARG_W-1:0] i_cmdArg,
  input  logic             i_btnStep,
  input  logic             i_swInstrNCycle,
  input  logic             i_instrFinished,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_clkEn,
  output logic             o_halted,
  output logic             o_done,
  output logic             o_bpHit,
  output logic             o_cmdErr,
  output logic [CNT_W-1:0] o_cycleCount,
  output logic [CNT_W-1:0] o_instrCount
);

  state_e           state_q, state_d;
  logic             clk_en_q, clk_en_d;
  logic             done_q, done_d;
  logic             bp_hit_q, bp_hit_d;
  logic             cmd_err_q, cmd_err_d;
  logic             start_q, start_d;
  logic [ARG_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  cmd_e cmd;
  logic btn_rise;
  logic instr_end, go_cmd, halt_cmd, zero_run, bp_match;

  assign cmd = cmd_e'(i_cmd);

  sync_edge u_btn_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_btnStep),
    .o_rise  (btn_rise)
  );

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [PC_W-1:0] bp_q, bp_d;
  logic            bp_valid_q, bp_valid_d;
`else
  logic unused_pc;
  assign unused_pc = ^i_pc;
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    bp_hit_d  = bp_hit_q;
    cmd_err_d = 1'b0;
    start_d   = 1'b0;
    zero_run  = 1'b0;
    bp_match  = 1'b0;
    instr_end = clk_en_q & i_instrFinished;
    go_cmd    = i_cmdValid & is_go(cmd);
    halt_cmd  = i_cmdValid & (cmd == CMD_HALT);
`ifdef RUN_CTRL_BREAKPOINT_EN
    bp_d       = bp_q;
    bp_valid_d = bp_valid_q;
    bp_match   = instr_end & bp_valid_q & (i_pc == bp_q) & (state_q != ST_STEP_CYC);
    if (i_cmdValid && cmd == CMD_SET_BP) begin
      bp_d       = i_cmdArg[PC_W-1:0];
      bp_valid_d = 1'b1;
    end
    if (i_cmdValid && cmd == CMD_CLR_BP) bp_valid_d = 1'b0;
`else
    if (i_cmdValid && (cmd == CMD_SET_BP || cmd == CMD_CLR_BP)) cmd_err_d = 1'b1;
`endif

    case (state_q)
      ST_HALTED: begin
        if (start_q) begin
          state_d = ST_RUN;
        end else if (go_cmd) begin
          bp_hit_d = 1'b0;
          case (cmd)
            CMD_RUN:        state_d = ST_RUN;
            CMD_STEP_CYC:   state_d = ST_STEP_CYC;
            CMD_STEP_INSTR: state_d = ST_STEP_INSTR;
            default: begin
              n_d = i_cmdArg;
              if (i_cmdArg == '0) zero_run = 1'b1;
              else                state_d  = ST_RUN_N;
            end
          endcase
        end else if (btn_rise && !i_cmdValid) begin
          // Button edges coinciding with any command are dropped.
          bp_hit_d = 1'b0;
          state_d  = i_swInstrNCycle ? ST_STEP_INSTR : ST_STEP_CYC;
        end
      end
      ST_STEP_CYC:   state_d = ST_HALTED;
      ST_STEP_INSTR: if (instr_end) state_d = ST_HALTED;
      ST_RUN_N: begin
        n_d = n_q - ARG_W'(1);
        if (n_q == ARG_W'(1)) state_d = ST_HALTED;
      end
      default: ;
    endcase

    if (state_q != ST_HALTED) begin
      if (go_cmd) cmd_err_d = 1'b1;
      if (halt_cmd || bp_match) state_d = ST_HALTED;
      if (bp_match) bp_hit_d = 1'b1;
    end

    clk_en_d = (state_d != ST_HALTED);
    done_d   = zero_run | ((state_q != ST_HALTED) && (state_d == ST_HALTED));
    cycle_d  = cycle_q + CNT_W'(clk_en_q);
    instr_d  = instr_q + CNT_W'(instr_end);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_HALTED;
      clk_en_q  <= 1'b0;
      done_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      start_q   <= (RESET_RUN != 0);
      n_q       <= '0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_en_q  <= clk_en_d;
      done_q    <= done_d;
      bp_hit_q  <= bp_hit_d;
      cmd_err_q <= cmd_err_d;
      start_q   <= start_d;
      n_q       <= n_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bp_q       <= '0;
      bp_valid_q <= 1'b0;
    end else begin
      bp_q       <= bp_d;
      bp_valid_q <= bp_valid_d;
    end
  end
  assign o_bpHit = bp_hit_q;
`else
  // bp_hit_q can never set without the compare.
  assign o_bpHit = 1'b0;
  logic unused_bp_hit;
  assign unused_bp_hit = bp_hit_q;
`endif

  assign o_clkEn      = clk_en_q;
  assign o_halted     = (state_q == ST_HALTED);
  assign o_done       = done_q;
  assign o_cmdErr     = cmd_err_q;
  assign o_cycleCount = cycle_q;
  assign o_instrCount = instr_q;

endmodule
